// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment scanner with dead-time and leading-zero blanking.
// Define SEVEN_SEG_SCAN_DP_EN to add per-digit decimal points (i_dp / o_seg_dp).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int DEAD_CLKS      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_lz_blank,
`ifdef SEVEN_SEG_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic                    o_seg_dp,
`endif
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig_en,
  output logic                    o_frame_done
);

  localparam int CNT_MAX = (CLKS_PER_DIGIT > DEAD_CLKS) ? CLKS_PER_DIGIT : DEAD_CLKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CLKS - 1);
  localparam logic [CW-1:0] ON_LAST   = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] ON_PENULT = CW'(CLKS_PER_DIGIT - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  typedef enum logic {ST_DEAD, ST_ON} state_t;

  state_t                  state_reg;
  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [4*NUM_DIGITS-1:0] pending_reg;
  logic [4*NUM_DIGITS-1:0] display_reg;
  logic [NUM_DIGITS-1:0]   blank_reg;
  logic [6:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   dig_en_reg;
  logic                    frame_done_reg;

  logic [3:0]              disp_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_next;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    dead_done;
  logic                    on_done;
  logic                    frame_xfer;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;  4'h1: seg = 7'h30;  4'h2: seg = 7'h6D;  4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;  4'h5: seg = 7'h5B;  4'h6: seg = 7'h5F;  4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h7B;  4'hA: seg = 7'h77;  4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;  4'hD: seg = 7'h3D;  4'hE: seg = 7'h4F;  default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign disp_nib[gi] = display_reg[4*gi +: 4];
    end
  endgenerate

  // Blank mask is computed from the value about to become the display value.
  always_comb begin
    logic lead;
    lead       = 1'b1;
    blank_next = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead          = lead & (pending_reg[4*k +: 4] == 4'h0);
      blank_next[k] = i_lz_blank & lead;
    end
  end

  always_comb begin
    onehot          = '0;
    onehot[idx_reg] = 1'b1;
  end

  assign dead_done  = (state_reg == ST_DEAD) && (cnt_reg == DEAD_LAST);
  assign on_done    = (state_reg == ST_ON) && (cnt_reg == ON_LAST);
  assign frame_xfer = on_done && (idx_reg == IDX_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_DEAD;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pending_reg    <= '0;
      display_reg    <= '0;
      blank_reg      <= '0;
      seg_reg        <= SEG_OFF;
      dig_en_reg     <= DIG_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (i_load) pending_reg <= i_value;
      if (state_reg == ST_DEAD) begin
        if (dead_done) begin
          state_reg <= ST_ON;
          cnt_reg   <= '0;
          if (!blank_reg[idx_reg]) begin
            seg_reg    <= hex_to_seg(disp_nib[idx_reg]) ^ SEG_OFF;
            dig_en_reg <= onehot ^ DIG_OFF;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        if (on_done) begin
          state_reg  <= ST_DEAD;
          cnt_reg    <= '0;
          seg_reg    <= SEG_OFF;
          dig_en_reg <= DIG_OFF;
          idx_reg    <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
          if (frame_xfer) begin
            display_reg <= pending_reg;
            blank_reg   <= blank_next;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
          // Registered pulse lands on the final ON cycle of the last digit.
          if ((idx_reg == IDX_LAST) && (cnt_reg == ON_PENULT)) frame_done_reg <= 1'b1;
        end
      end
    end
  end

`ifdef SEVEN_SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] dp_pending_reg;
  logic [NUM_DIGITS-1:0] dp_display_reg;
  logic                  seg_dp_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dp_pending_reg <= '0;
      dp_display_reg <= '0;
      seg_dp_reg     <= SEG_ACTIVE_LOW;
    end else begin
      if (i_load) dp_pending_reg <= i_dp;
      if (frame_xfer) dp_display_reg <= dp_pending_reg;
      if (dead_done && !blank_reg[idx_reg])
        seg_dp_reg <= dp_display_reg[idx_reg] ^ SEG_ACTIVE_LOW;
      else if (on_done)
        seg_dp_reg <= SEG_ACTIVE_LOW;
    end
  end

  assign o_seg_dp = seg_dp_reg;
`endif

  assign o_seg        = seg_reg;
  assign o_dig_en     = dig_en_reg;
  assign o_frame_done = frame_done_reg;

endmodule
